instr_fetch_queue: RTL and testbench

Instruction fetch unit with prefetch queue: reads RV32I instruction words from program memory at sequential byte addresses (PC += 4), buffers them in an in-order FIFO, and presents them with their PC to the decode stage through a valid/ready handshake. It sits between `program_counter`/`mem_prog` and the core's decoder. A redirect input (branch/jump target) flushes the queue and discards responses still in flight.

---
 rtl/instr_fetch_queue.sv | 210 +++++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction fetch unit with a prefetch queue. Issues sequential word fetches
// (PC += 4) to program memory, buffers returned words with their fetch PC in
// an in-order FIFO, and hands them to the decoder over a valid/ready
// handshake. A redirect flushes the queue, restarts fetch at a new PC and
// discards every response that was still in flight.
//
// Parameters:
//   DEPTH     queue entries plus in-flight requests combined (power of 2, 2..16)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   mem_req/mem_addr/mem_gnt    fetch request channel (req && gnt = issue)
//   mem_rvalid/mem_rdata        in-order read responses, >= 1 cycle after grant
//   redirect_valid/redirect_pc  flush and restart fetch at redirect_pc & ~3
//   instr_valid/instr_ready     decoder handshake on the queue head
//   instr/instr_pc              head instruction word and its fetch address
//   instr_illegal               predecode flag of the head
//
// Build option:
//   FETCH_PREDECODE_EN  when defined, each pushed word is predecoded and an
//                       illegal-opcode flag is stored per entry; otherwise
//                       instr_illegal is tied low.
// ----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_illegal
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          run_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q,  drop_d;
    logic [AW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [AW-1:0] t_rd_q, t_rd_d, t_wr_q, t_wr_d;

    logic [31:0]   q_instr_mem [DEPTH];
    logic [31:0]   q_pc_mem    [DEPTH];
    logic [31:0]   tag_mem     [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;

    // Low address bits of the redirect target are ignored by design.
    logic          unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // ------------------------------------------------------------------
    // Request / response / pop qualifiers
    // ------------------------------------------------------------------
    // Credit check: every in-flight request already owns a queue slot, so a
    // response can always be pushed and the queue can never overflow.
    assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
    // run_q keeps the request low while reset is asserted (all counters are
    // zero then, so the credit check alone would request).
    assign mem_req     = run_q && (credit_used < DEPTH_LIM);
    assign mem_addr    = fetch_pc_q;
    assign issue       = mem_req && mem_gnt;

    assign instr_valid = (count_q != '0);
    // A response in the redirect cycle belongs to the old stream; so does
    // any response while drop is non-zero.
    assign push        = mem_rvalid && !redirect_valid && (drop_q == '0);
    // A pop in the redirect cycle is ignored: the queue is flushed anyway.
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        q_rd_d     = q_rd_q;
        q_wr_d     = q_wr_q;

        // In-flight tracking is independent of redirect: dropped responses
        // still return and still consume their tag.
        outst_d = outst_q + CW'(issue) - CW'(mem_rvalid);
        t_wr_d  = t_wr_q + AW'(issue);
        t_rd_d  = t_rd_q + AW'(mem_rvalid);

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            q_rd_d     = '0;
            q_wr_d     = '0;
            // Discard everything still outstanding after this cycle,
            // including a request granted in the redirect cycle itself.
            drop_d     = outst_d;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;   // wraps FFFF_FFFC -> 0
            end
            if (mem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            q_wr_d  = q_wr_q + AW'(push);
            q_rd_d  = q_rd_q + AW'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            q_rd_q     <= '0;
            q_wr_q     <= '0;
            t_rd_q     <= '0;
            t_wr_q     <= '0;
        end else begin
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            q_rd_q     <= q_rd_d;
            q_wr_q     <= q_wr_d;
            t_rd_q     <= t_rd_d;
            t_wr_q     <= t_wr_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage arrays
    // ------------------------------------------------------------------
    // NOTE: the arrays carry no reset; an entry is only read while the
    // count says it is valid, and the outputs are masked to zero otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr_mem[q_wr_q] <= mem_rdata;
            q_pc_mem[q_wr_q]    <= tag_mem[t_rd_q];
        end
        if (issue) begin
            tag_mem[t_wr_q] <= fetch_pc_q;
        end
    end

    assign instr    = instr_valid ? q_instr_mem[q_rd_q] : '0;
    assign instr_pc = instr_valid ? q_pc_mem[q_rd_q]    : '0;

`ifdef FETCH_PREDECODE_EN
    // Flags words that are not a 32-bit RV32I base opcode.
    function automatic logic predecode_illegal(input logic [31:0] w);
        logic bad;
        case (w[6:0])
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
            7'b0110011, 7'b0001111, 7'b1110011: bad = 1'b0;
            default:                            bad = 1'b1;
        endcase
        if (w[1:0] != 2'b11) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    logic q_ill_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            q_ill_mem[q_wr_q] <= predecode_illegal(mem_rdata);
        end
    end

    assign instr_illegal = instr_valid && q_ill_mem[q_rd_q];
`else
    assign instr_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Directed bench for instr_fetch_queue (DEPTH=4, RESET_PC=0). A small memory
// responder returns words a fixed number of cycles after each grant; the
// directed sequence covers reset, sequential fetch, back-pressure, redirect
// with in-flight drops, coincident redirect/response/grant and PC wrap.
// ----------------------------------------------------------------------------
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_illegal;

`ifdef FETCH_PREDECODE_EN
    localparam logic PD = 1'b1;
`else
    localparam logic PD = 1'b0;
`endif

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_illegal (instr_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;

    // ------------------------------------------------------------------
    // Program memory model
    // ------------------------------------------------------------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0193;   // ADDI x3,x0,5
            32'h0000_0004: return 32'h0041_82B3;   // ADD  x5,x3,x4
            32'h0000_0008: return 32'h0010_A283;   // LW   x5,1(x1)
            32'h0000_000C: return 32'h0000_0000;   // illegal
            default:       return 32'h0000_0013 | (a << 12);  // OP-IMM
        endcase
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    cyc    = 0;
    int    lat    = 1;
    int    gcount = 0;
    logic  gnt_en = 1'b1;

    always @(posedge clk) cyc++;

    // Drives memory inputs at the falling edge for the upcoming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            mem_gnt    = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (pend.size() > 0 && pend[0].due == cyc + 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end
            mem_gnt = gnt_en;
            if (mem_req && gnt_en) begin
                pend.push_back('{addr: mem_addr, due: cyc + 1 + lat});
                gcount++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = '0;

        // Reset state
        step();
        step();
        check("rst_mem_req",   32'(mem_req),       32'd0);
        check("rst_mem_addr",  mem_addr,           32'h0);
        check("rst_valid",     32'(instr_valid),   32'd0);
        check("rst_instr",     instr,              32'h0);
        check("rst_pc",        instr_pc,           32'h0);
        check("rst_illegal",   32'(instr_illegal), 32'd0);

        // Sequential fetch, L=1, decoder stalled
        rst_n = 1'b1;
        step();                                           // P1
        check("p1_mem_req",    32'(mem_req),       32'd1);
        check("p1_mem_addr",   mem_addr,           32'h0);
        step();                                           // P2: grant addr 0
        check("p2_mem_addr",   mem_addr,           32'h4);
        check("p2_valid",      32'(instr_valid),   32'd0);
        step();                                           // P3: rvalid addr 0
        check("p3_mem_addr",   mem_addr,           32'h8);
        check("p3_valid",      32'(instr_valid),   32'd1);
        check("p3_instr",      instr,              32'h0050_0193);
        check("p3_pc",         instr_pc,           32'h0);
        check("p3_illegal",    32'(instr_illegal), 32'd0);
        step(); step(); step();                           // P6
        check("full_mem_req",  32'(mem_req),       32'd0);
        check("stall_instr",   instr,              32'h0050_0193);
        check("stall_pc",      instr_pc,           32'h0);
        step(); step(); step();                           // P9
        check("full_grants",   32'(gcount),        32'd4);
        check("full_mem_req2", 32'(mem_req),       32'd0);

        // Release back-pressure: one pop per cycle
        instr_ready = 1'b1;
        step();                                           // P10
        check("pop1_instr",    instr,              32'h0041_82B3);
        check("pop1_pc",       instr_pc,           32'h4);
        check("pop1_mem_req",  32'(mem_req),       32'd1);
        check("pop1_mem_addr", mem_addr,           32'h10);
        step();                                           // P11
        check("lw_instr",      instr,              32'h0010_A283);
        check("lw_pc",         instr_pc,           32'h8);
        check("lw_illegal",    32'(instr_illegal), 32'd0);
        step();                                           // P12
        check("zero_instr",    instr,              32'h0);
        check("zero_pc",       instr_pc,           32'hC);
        check("zero_illegal",  32'(instr_illegal), 32'(PD));
        step();                                           // P13
        check("refill_instr",  instr,              32'h0001_0013);
        check("refill_pc",     instr_pc,           32'h10);

        // Mid-operation reset, then redirect with 3 in flight at L=3
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        lat         = 3;
        #1;
        check("areset_valid",   32'(instr_valid),  32'd0);
        check("areset_mem_req", 32'(mem_req),      32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();                                           // R1
        step();                                           // R2: grant 0
        step();                                           // R3: grant 4
        step();                                           // R4: grant 8
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        gnt_en         = 1'b0;
        step();                                           // R5: rvalid 0 (drop)
        redirect_valid = 1'b0;
        gnt_en         = 1'b1;
        check("rd_valid",      32'(instr_valid),   32'd0);
        check("rd_mem_addr",   mem_addr,           32'h40);
        check("rd_mem_req",    32'(mem_req),       32'd1);
        for (int i = 0; i < 3; i++) begin                 // R6..R8
            step();
            check($sformatf("rd_nostale%0d", i), 32'(instr_valid), 32'd0);
        end
        step();                                           // R9
        check("rd_new_valid",  32'(instr_valid),   32'd1);
        check("rd_new_pc",     instr_pc,           32'h40);
        check("rd_new_instr",  instr,              32'h0004_0013);

        // Redirect coincident with a response and a grant, target wraps
        rst_n       = 1'b0;
        lat         = 1;
        instr_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();                                           // S1
        step();                                           // S2: grant 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();                                           // S3: rvalid 0 + grant 4
        redirect_valid = 1'b0;
        check("co_valid",      32'(instr_valid),   32'd0);
        check("co_mem_addr",   mem_addr,           32'hFFFF_FFFC);
        check("co_mem_req",    32'(mem_req),       32'd1);
        step();                                           // S4: rvalid 4 dropped
        check("co_valid2",     32'(instr_valid),   32'd0);
        check("wrap_mem_addr", mem_addr,           32'h0);
        step();                                           // S5
        check("wrap_valid",    32'(instr_valid),   32'd1);
        check("wrap_pc",       instr_pc,           32'hFFFF_FFFC);
        check("wrap_instr",    instr,              32'hFFFF_C013);
        for (int i = 0; i < 3; i++) begin                 // S6..S8
            step();
            check($sformatf("tput_valid%0d", i), 32'(instr_valid), 32'd1);
            check($sformatf("tput_pc%0d", i),    instr_pc,         32'(4 * i));
        end
        check("tput_instr",    instr,              32'h0010_A283);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
